// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the RV32M divide sequencer.
interface div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic [4:0]            rd_in;
  logic                  flush;
  logic                  stall;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;
  logic [4:0]            result_rd;

  modport master (
    output start, op, dividend, divisor, rd_in, flush,
    input  stall, result_valid, result, result_rd
  );

  modport slave (
    input  start, op, dividend, divisor, rd_in, flush,
    output stall, result_valid, result, result_rd
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with single-cycle handling of divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for a divide request from execute
// BUSY  | shift-subtract loop running, pipeline stalled
// DONE  | result_valid pulse, stall released
module div_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic [DW-1:0] dividend_reg;
  logic [DW-1:0] divisor_reg;
  logic [1:0]    op_reg;
  logic          q_neg;
  logic          r_neg;
  logic [DW-1:0] result_reg;
  logic [4:0]    result_rd_reg;
  logic          result_valid_reg;

  logic          is_signed;
  logic [DW-1:0] abs_dividend;
  logic [DW-1:0] abs_divisor;
  logic          div_zero;
  logic          overflow;
  logic [DW:0]   trial;
  logic [DW-1:0] rem_next;
  logic [DW-1:0] quo_next;

  always_comb begin
    is_signed    = ~bus.op[0];
    abs_dividend = (is_signed && bus.dividend[DW-1]) ? -bus.dividend : bus.dividend;
    abs_divisor  = (is_signed && bus.divisor[DW-1])  ? -bus.divisor  : bus.divisor;
    div_zero     = (bus.divisor == '0);
    overflow     = is_signed && (bus.dividend == {1'b1, {(DW-1){1'b0}}}) && (bus.divisor == '1);
    // remainder[DW-1] is always 0 before the last step, so dropping it loses nothing
    trial = {1'b0, remainder[DW-2:0], dividend_reg[DW-1]} - {1'b0, divisor_reg};
    if (!trial[DW]) begin
      rem_next = trial[DW-1:0];
      quo_next = {quotient[DW-2:0], 1'b1};
    end else begin
      rem_next = {remainder[DW-2:0], dividend_reg[DW-1]};
      quo_next = {quotient[DW-2:0], 1'b0};
    end
  end

  assign bus.stall        = ~rst & ~bus.flush & (((state == IDLE) & bus.start) | (state == BUSY));
  assign bus.result_valid = result_valid_reg;
  assign bus.result       = result_reg;
  assign bus.result_rd    = result_rd_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      quotient         <= '0;
      remainder        <= '0;
      dividend_reg     <= '0;
      divisor_reg      <= '0;
      op_reg           <= '0;
      q_neg            <= 1'b0;
      r_neg            <= 1'b0;
      result_reg       <= '0;
      result_rd_reg    <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              op_reg        <= bus.op;
              result_rd_reg <= bus.rd_in;
              dividend_reg  <= abs_dividend;
              divisor_reg   <= abs_divisor;
              q_neg         <= is_signed & (bus.dividend[DW-1] ^ bus.divisor[DW-1]);
              r_neg         <= is_signed & bus.dividend[DW-1];
              count         <= '0;
              remainder     <= '0;
              quotient      <= '0;
              if (div_zero || overflow) begin
                state            <= DONE;
                result_valid_reg <= 1'b1;
                if (!bus.op[1])
                  result_reg <= div_zero ? '1 : {1'b1, {(DW-1){1'b0}}};
                else
                  result_reg <= div_zero ? bus.dividend : '0;
              end else begin
                state <= BUSY;
              end
            end
          end
          BUSY: begin
            remainder    <= rem_next;
            quotient     <= quo_next;
            dividend_reg <= dividend_reg << 1;
            count        <= count + 1'b1;
            if (count == CW'(DW - 1)) begin
              state            <= DONE;
              result_valid_reg <= 1'b1;
              if (op_reg[1])
                result_reg <= r_neg ? -rem_next : rem_next;
              else
                result_reg <= q_neg ? -quo_next : quo_next;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed RV32M cases plus randomized divides
// checked against an arithmetic reference model.
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] exp_res[$];
  logic [4:0]  exp_rd[$];

  always #5 clk = ~clk;

  div_if #(.DATA_WIDTH(32)) bus();
  div_sequencer #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    logic sgn;
    sgn = (op == 2'b00) || (op == 2'b10);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Monitor: every result_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      check("scoreboard_nonempty", 32'(exp_res.size() > 0), 32'd1);
      if (exp_res.size() > 0) begin
        logic [31:0] r;
        logic [4:0]  d;
        r = exp_res.pop_front();
        d = exp_rd.pop_front();
        check("result", bus.result, r);
        check("result_rd", {27'd0, bus.result_rd}, {27'd0, d});
      end
    end
  end

  // Called just after a rising edge; holds start high like a stalled execute stage
  // and returns just after the rising edge that follows DONE.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int   lat, idx, stalls;
    logic sp;
    sp  = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    lat = sp ? 1 : 33;
    exp_res.push_back(ref_model(op, a, b));
    exp_rd.push_back(rd);
    bus.start = 1'b1; bus.op = op; bus.dividend = a; bus.divisor = b; bus.rd_in = rd;
    idx = 0; stalls = 0;
    forever begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) break;
      if (bus.stall === 1'b1) stalls++;
      idx++;
      if (idx > 60) break;
    end
    check("valid_cycle", 32'(idx), 32'(lat));
    check("stall_cycles", 32'(stalls), 32'(lat));
    check("stall_in_done", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd100; bus.divisor = 32'd7;
    bus.rd_in = 5'd9; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_valid", {31'd0, bus.result_valid}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_rd", {27'd0, bus.result_rd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    idle(1);

    // Directed cases
    issue(2'b01, 32'd100, 32'd7, 5'd3);
    idle(1);
    issue(2'b00, 32'hFFFF_FFEC, 32'd3, 5'd4);
    issue(2'b10, 32'hFFFF_FFEC, 32'd3, 5'd5);
    idle(1);
    issue(2'b00, 32'd5, 32'd0, 5'd6);
    idle(1);
    issue(2'b11, 32'd5, 32'd0, 5'd7);
    idle(1);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    idle(1);

    // Flush in BUSY cycle 10, then a fresh DIVU two cycles later
    bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd1000; bus.divisor = 32'd7; bus.rd_in = 5'd12;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 9) check("stall_before_flush", {31'd0, bus.stall}, 32'd1);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("stall_on_flush", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("stall_after_flush", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    issue(2'b01, 32'd9, 32'd3, 5'd13);
    idle(1);

    // Reset in BUSY cycle 5 with start still high
    bus.start = 1'b1; bus.op = 2'b00; bus.dividend = 32'd77; bus.divisor = 32'd5; bus.rd_in = 5'd14;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("stall_in_reset", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_stall", {31'd0, bus.stall}, 32'd0);
    check("post_reset_valid", {31'd0, bus.result_valid}, 32'd0);
    check("post_reset_result", bus.result, 32'd0);
    check("post_reset_rd", {27'd0, bus.result_rd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    idle(40);

    // Randomized divides with varied gaps, including back-to-back
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          kind;
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      kind = $urandom_range(0, 7);
      if (kind == 0) b = 32'd0;
      else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (kind == 2) b = 32'($urandom_range(1, 15));
      else if (kind == 3) begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 60)); end
      issue(op, a, b, 5'($urandom_range(0, 31)));
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("scoreboard_drained", 32'(exp_res.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle sequencer and iterative datapath for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU), driven from the execute stage.
- Accepts a divide request, holds the front of the pipeline with a stall signal and runs a restoring shift-subtract loop, one quotient bit per cycle.
- Returns the result with a one-cycle valid pulse, which releases the stall.
- Handles the RISC-V divide-by-zero and signed-overflow cases in a single cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  divide instruction valid in execute
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  DATA_WIDTH  rs1 value, forwarded
- divisor  in  DATA_WIDTH  rs2 value, forwarded
- rd_in  in  5  destination register tag
- flush  in  1  kill the in-flight operation
- stall  out  1  hold PC, F/D and D/E; suppress E/M write enables
- result_valid  out  1  one-cycle pulse, result ready
- result  out  DATA_WIDTH  quotient or remainder
- result_rd  out  5  latched rd_in

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset: state IDLE; count, quotient, remainder and all operand registers 0; result 0; result_rd 0; result_valid 0; stall 0. Reset overrides every other input, including in mid-operation.
- IDLE with start=1 and flush=0:
  - Latch op and rd_in.
  - Latch abs(dividend) and abs(divisor) for signed ops; raw values for unsigned ops.
  - Latch the sign flags: q_neg = signed op & (dividend[31] ^ divisor[31]); r_neg = signed op & dividend[31].
  - If divisor==0, or signed op with dividend==0x80000000 and divisor==0xFFFFFFFF: go to DONE with the special result loaded.
  - Otherwise: go to BUSY with count=0 and remainder=0.
- stall is combinational:
  - stall = (IDLE & start & ~flush) | BUSY.
  - stall is 0 in DONE, so the instruction leaves execute in the cycle result_valid=1.
- BUSY, each cycle:
  - trial = {remainder[30:0], dividend_reg[31]} - divisor_reg, computed 33 bits wide.
  - If trial is non-negative: remainder takes the trial value and quotient bit = 1. Otherwise remainder is the shifted value and quotient bit = 0.
  - dividend_reg shifts left by 1; the quotient bit shifts into quotient[0].
  - count increments. When count == DATA_WIDTH-1, go to DONE after that cycle's update.
- DONE: result_valid=1 for exactly one cycle. Next state is IDLE unconditionally; start is ignored in DONE because the same instruction is still in execute.
- Result selection (registered on entry to DONE):
  - DIV/DIVU: q_neg ? -quotient : quotient.
  - REM/REMU: r_neg ? -remainder : remainder.
- Special results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = original dividend.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- Latency:
  - Normal: start seen in cycle 0, BUSY in cycles 1..32, DONE in cycle 33. stall is high in cycles 0..32 (33 cycles).
  - Special case: DONE in cycle 1; stall is high in cycle 0 only.
- start while in BUSY is ignored; operands are not re-sampled.
- flush=1 in any state: next state IDLE, result_valid stays 0 (including a flush arriving in the cycle the FSM would enter DONE), and stall is forced 0 that cycle. Flush beats start in the same cycle.
- Back-to-back divides: the next start arriving in the cycle after DONE is accepted from IDLE normally.
- Arithmetic: unsigned magnitudes throughout; negation is two's complement modulo 2^32. abs(0x80000000) = 0x80000000 treated as unsigned.

Test Plan:
- DIVU 100/7: start 1 cycle, then hold start high → stall high for 33 cycles; result_valid in cycle 33; result 14; result_rd = rd_in.
- DIV -20/3 then REM -20/3 (back-to-back, second start the cycle after DONE) → 0xFFFFFFFA (-6), then 0xFFFFFFFE (-2); each stall window is 33 cycles.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Both have result_valid in cycle 1 and stall high for 1 cycle.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Both use the 1-cycle path.
- Flush in BUSY cycle 10 → stall drops that cycle; no result_valid pulse; a new DIVU 9/3 issued 2 cycles later returns 3.
- rst asserted in BUSY cycle 5 → next cycle IDLE, stall 0, result 0, result_valid 0; start held high during reset is not accepted.
